// File: rtl/seq_binary_to_7seg.sv
// Multi-cycle signed binary to 7-segment driver: sign display plus DIGITS
// decimal magnitude displays, converted by a double-dabble engine with a start/busy/done handshake.
module seq_binary_to_7seg #(
    parameter int W      = 11,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          n,
    input  logic                  encoding,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            sign,
    output logic [7*DIGITS-1:0]   digits,
    output logic                  too_large
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAXVAL = pow10(DIGITS) - 1;

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0:    segOf = 7'h40;
            4'd1:    segOf = 7'h79;
            4'd2:    segOf = 7'h24;
            4'd3:    segOf = 7'h30;
            4'd4:    segOf = 7'h19;
            4'd5:    segOf = 7'h12;
            4'd6:    segOf = 7'h02;
            4'd7:    segOf = 7'h78;
            4'd8:    segOf = 7'h00;
            4'd9:    segOf = 7'h10;
            default: segOf = SEG_OFF;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [BW-1:0]   bcd_q;
    logic [W-1:0]    mag_q;
    logic            neg_q;
    logic            ovf_q;

    logic            neg_in;
    logic [W-1:0]    mag_in;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_step;
    logic [W-1:0]    mag_step;
    logic [6:0]      sign_next;
    logic [7*DIGITS-1:0] digits_next;
    logic            accept;
    logic            blank;

    assign busy   = (state_q == CONVERT);
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONVERT;
            CONVERT: if (count_q == CW'(1)) state_d = DONE;
            DONE:    state_d = start ? CONVERT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Two's-complement -2^(W-1) negates to 2^(W-1), which still fits in W unsigned bits.
    always_comb begin
        neg_in = n[W-1];
        if (encoding && neg_in)
            mag_in = ~n + 1'b1;
        else if (encoding)
            mag_in = n;
        else
            mag_in = {1'b0, n[W-2:0]};
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_step, mag_step} = {bcd_adj, mag_q} << 1;
    end

    // Display values come from the BCD after the final step, so they are ready on the edge entering DONE.
    always_comb begin
        digits_next = '0;
        blank       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((bcd_step[4*i +: 4] != 4'd0) || (i == 0))
                blank = 1'b0;
            if (ovf_q)
                digits_next[7*i +: 7] = SEG_MINUS;
            else if (blank)
                digits_next[7*i +: 7] = SEG_OFF;
            else
                digits_next[7*i +: 7] = segOf(bcd_step[4*i +: 4]);
        end
        if (ovf_q || (neg_q && (bcd_step != '0)))
            sign_next = SEG_MINUS;
        else
            sign_next = SEG_OFF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bcd_q     <= '0;
            mag_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            too_large <= 1'b0;
            sign      <= SEG_OFF;
            digits    <= {DIGITS{SEG_OFF}};
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (accept) begin
                mag_q   <= mag_in;
                neg_q   <= neg_in;
                ovf_q   <= (64'(mag_in) > MAXVAL);
                count_q <= CW'(W);
                bcd_q   <= '0;
            end else if (state_q == CONVERT) begin
                bcd_q   <= bcd_step;
                mag_q   <= mag_step;
                count_q <= count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    done      <= 1'b1;
                    too_large <= ovf_q;
                    sign      <= sign_next;
                    digits    <= digits_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_binary_to_7seg.sv
// Directed self-checking bench for seq_binary_to_7seg at W=11, DIGITS=3.
module tb_seq_binary_to_7seg;

    logic        clock;
    logic        reset;
    logic        start;
    logic [10:0] n;
    logic        encoding;
    logic        busy;
    logic        done;
    logic [6:0]  sign;
    logic [20:0] digits;
    logic        too_large;

    int checks = 0;
    int errors = 0;

    seq_binary_to_7seg #(.W(11), .DIGITS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .n         (n),
        .encoding  (encoding),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .digits    (digits),
        .too_large (too_large)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one start pulse; returns at the falling edge of the first busy cycle.
    task automatic applyStimulus(input logic [10:0] value, input logic enc);
        n        = value;
        encoding = enc;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic waitDone(output int busyCycles, output int waited);
        busyCycles = 0;
        waited     = 0;
        while (!done && waited < 40) begin
            if (busy) busyCycles++;
            @(negedge clock);
            waited++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [6:0] expSign,
                               input logic [20:0] expDigits, input logic expTl);
        checkOutput({tag, ".sign"}, 32'(sign), 32'(expSign));
        checkOutput({tag, ".digits"}, 32'(digits), 32'(expDigits));
        checkOutput({tag, ".too_large"}, 32'(too_large), 32'(expTl));
    endtask

    task automatic convertAndCheck(input string tag, input logic [10:0] value, input logic enc,
                                   input logic [6:0] expSign, input logic [20:0] expDigits,
                                   input logic expTl);
        int bc;
        int wt;
        applyStimulus(value, enc);
        waitDone(bc, wt);
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkResult(tag, expSign, expDigits, expTl);
        @(negedge clock);
    endtask

    initial begin
        int bc;
        int wt;
        int doneCount;

        reset    = 1'b1;
        start    = 1'b0;
        n        = '0;
        encoding = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        $display("[TB] reset state");
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkResult("rst", 7'h7F, 21'h1FFFFF, 1'b0);

        $display("[TB] 725 two's complement with timing");
        applyStimulus(11'd725, 1'b1);
        waitDone(bc, wt);
        checkOutput("725.busy_cycles", 32'(bc), 32'd11);
        checkOutput("725.latency", 32'(wt), 32'd11);
        checkOutput("725.done", 32'(done), 32'd1);
        checkOutput("725.busy_at_done", 32'(busy), 32'd0);
        checkResult("725", 7'h7F, {7'h78, 7'h24, 7'h12}, 1'b0);
        @(negedge clock);
        checkOutput("725.done_pulse", 32'(done), 32'd0);
        checkOutput("725.hold", 32'(digits), 32'({7'h78, 7'h24, 7'h12}));

        convertAndCheck("tc_m3",   11'h7FD, 1'b1, 7'h3F, {7'h7F, 7'h7F, 7'h30}, 1'b0);
        convertAndCheck("sm_m3",   11'h403, 1'b0, 7'h3F, {7'h7F, 7'h7F, 7'h30}, 1'b0);
        convertAndCheck("tc_1000", 11'd1000, 1'b1, 7'h3F, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
        convertAndCheck("tc_min",  11'h400, 1'b1, 7'h3F, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
        convertAndCheck("sm_nz",   11'h400, 1'b0, 7'h7F, {7'h7F, 7'h7F, 7'h40}, 1'b0);
        convertAndCheck("sm_999",  11'd999, 1'b0, 7'h7F, {7'h10, 7'h10, 7'h10}, 1'b0);
        convertAndCheck("tc_m999", 11'h419, 1'b1, 7'h3F, {7'h10, 7'h10, 7'h10}, 1'b0);
        convertAndCheck("sm_m1023", 11'h7FF, 1'b0, 7'h3F, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
        convertAndCheck("tc_100",  11'd100, 1'b1, 7'h7F, {7'h79, 7'h40, 7'h40}, 1'b0);
        convertAndCheck("tc_5",    11'd5, 1'b1, 7'h7F, {7'h7F, 7'h7F, 7'h12}, 1'b0);

        $display("[TB] start while busy is ignored");
        applyStimulus(11'd123, 1'b1);
        repeat (2) @(negedge clock);
        n     = 11'd456;
        start = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) doneCount++;
            @(negedge clock);
        end
        checkOutput("ign.done_count", 32'(doneCount), 32'd1);
        checkResult("ign", 7'h7F, {7'h79, 7'h24, 7'h30}, 1'b0);

        $display("[TB] back-to-back start");
        applyStimulus(11'd725, 1'b1);
        waitDone(bc, wt);
        checkOutput("b2b.first_done", 32'(done), 32'd1);
        n        = 11'h7FD;
        encoding = 1'b1;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("b2b.busy", 32'(busy), 32'd1);
        waitDone(bc, wt);
        checkOutput("b2b.latency", 32'(wt), 32'd11);
        checkOutput("b2b.second_done", 32'(done), 32'd1);
        checkResult("b2b", 7'h3F, {7'h7F, 7'h7F, 7'h30}, 1'b0);
        @(negedge clock);

        $display("[TB] reset mid-conversion");
        applyStimulus(11'd725, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkResult("abort", 7'h7F, 21'h1FFFFF, 1'b0);
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) doneCount++;
            @(negedge clock);
        end
        checkOutput("abort.no_done", 32'(doneCount), 32'd0);
        checkOutput("abort.idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
